// File: rtl/nd_1ton_router.sv
`default_nettype none

// ============================================================================
// Module   : nd_1ton_router
// Purpose  : 1-to-N message router node. One 4-phase req/ack input channel is
//            routed by destination-address ranges (optionally broadcast to all
//            outputs) into one FIFO per output. Each FIFO drives its own
//            independent 4-phase output channel through a payload register.
// Ports    : i_clk, reset          clock, synchronous active-high reset
//            ready                  high once initialised after reset
//            rcv_src/dst/dat/red    input message fields
//            rcv_req / rcv_ack      input 4-phase handshake
//            snd_src/dst/dat/red    packed per-output message fields (k at [k*W+:W])
//            snd_req / snd_ack      per-output 4-phase handshake
//            occ                    packed per-output FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 16
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif

module nd_1ton_router #(
  parameter int NUM_OUT = 2,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE,
  parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
  // Ascending upper bounds of outputs 0..NUM_OUT-2; the last output takes the rest.
  parameter logic [(NUM_OUT-1)*ASZ-1:0] UPPER = ((NUM_OUT-1)*ASZ)'(7),
  parameter bit BCAST_EN = 1'b0,
  parameter logic [ASZ-1:0] BCAST_ADR = {ASZ{1'b1}}
) (
  input  logic                                  i_clk,
  input  logic                                  reset,
  output logic                                  ready,
  input  logic [ASZ-1:0]                        rcv_src,
  input  logic [ASZ-1:0]                        rcv_dst,
  input  logic [DSZ-1:0]                        rcv_dat,
  input  logic [RSZ-1:0]                        rcv_red,
  input  logic                                  rcv_req,
  output logic                                  rcv_ack,
  output logic [NUM_OUT*ASZ-1:0]                snd_src,
  output logic [NUM_OUT*ASZ-1:0]                snd_dst,
  output logic [NUM_OUT*DSZ-1:0]                snd_dat,
  output logic [NUM_OUT*RSZ-1:0]                snd_red,
  output logic [NUM_OUT-1:0]                    snd_req,
  input  logic [NUM_OUT-1:0]                    snd_ack,
  output logic [NUM_OUT*($clog2(FSZ)+1)-1:0]    occ
);

  localparam int PW = $clog2(FSZ) + 1;   // pointer width (one wrap bit)
  localparam int IW = PW - 1;            // storage index width
  localparam int MW = 2*ASZ + DSZ + RSZ; // packed message {src,dst,dat,red}

  logic                         ready_q, ready_d;
  logic                         rcv_ack_q, rcv_ack_d;
  logic [NUM_OUT-1:0]           snd_req_q, snd_req_d;
  logic [NUM_OUT-1:0][MW-1:0]   pay_q, pay_d;
  logic [NUM_OUT-1:0][PW-1:0]   head_q, head_d;
  logic [NUM_OUT-1:0][PW-1:0]   tail_q, tail_d;
  logic [MW-1:0]                mem_q [NUM_OUT][FSZ];

  logic [NUM_OUT-1:0]           w_tgt;
  logic [NUM_OUT-1:0][PW-1:0]   w_occ;
  logic [NUM_OUT-1:0]           w_full;
  logic [NUM_OUT-1:0]           w_empty;
  logic [NUM_OUT-1:0]           w_pop;
  logic [NUM_OUT-1:0]           w_push;
  logic                         w_room;
  logic                         w_accept;
  logic [MW-1:0]                w_msg;

  assign w_msg = {rcv_src, rcv_dst, rcv_dat, rcv_red};

  // Destination decode: first range whose upper bound covers the address,
  // otherwise the last output. Broadcast overrides the ranges.
  always_comb begin
    logic hit;
    hit   = 1'b0;
    w_tgt = '0;
    for (int k = 0; k < NUM_OUT-1; k++) begin
      if (!hit && (rcv_dst <= UPPER[k*ASZ +: ASZ])) begin
        w_tgt[k] = 1'b1;
        hit      = 1'b1;
      end
    end
    if (!hit) w_tgt[NUM_OUT-1] = 1'b1;
    if (BCAST_EN && (rcv_dst == BCAST_ADR)) w_tgt = '1;
  end

  // Pops only from a non-empty FIFO, so a message written this edge cannot
  // reach the output register until the next edge.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      w_occ[k]   = tail_q[k] - head_q[k];
      w_full[k]  = (w_occ[k] == PW'(FSZ));
      w_empty[k] = (w_occ[k] == '0);
      w_pop[k]   = !snd_req_q[k] && !snd_ack[k] && !w_empty[k];
    end
  end

  // A full target still has room if it pops on the same edge. Every target
  // must have room, which keeps broadcast writes all-or-nothing.
  assign w_room   = &(~w_tgt | ~w_full | w_pop);
  assign w_accept = ready_q && rcv_req && !rcv_ack_q && w_room;
  assign w_push   = w_tgt & {NUM_OUT{w_accept}};

  always_comb begin
    ready_d   = 1'b1;
    rcv_ack_d = rcv_ack_q;
    if (w_accept)      rcv_ack_d = 1'b1;
    else if (!rcv_req) rcv_ack_d = 1'b0;

    head_d    = head_q;
    tail_d    = tail_q;
    snd_req_d = snd_req_q;
    pay_d     = pay_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_push[k]) tail_d[k] = tail_q[k] + PW'(1);
      if (w_pop[k]) begin
        head_d[k]    = head_q[k] + PW'(1);
        pay_d[k]     = mem_q[k][head_q[k][IW-1:0]];
        snd_req_d[k] = 1'b1;
      end else if (snd_req_q[k] && snd_ack[k]) begin
        snd_req_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      rcv_ack_q <= 1'b0;
      snd_req_q <= '0;
      pay_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      ready_q   <= ready_d;
      rcv_ack_q <= rcv_ack_d;
      snd_req_q <= snd_req_d;
      pay_q     <= pay_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_push[k]) mem_q[k][tail_q[k][IW-1:0]] <= w_msg;
    end
  end

  assign ready   = ready_q;
  assign rcv_ack = rcv_ack_q;
  assign snd_req = snd_req_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign snd_red[k*RSZ +: RSZ] = pay_q[k][0 +: RSZ];
    assign snd_dat[k*DSZ +: DSZ] = pay_q[k][RSZ +: DSZ];
    assign snd_dst[k*ASZ +: ASZ] = pay_q[k][RSZ+DSZ +: ASZ];
    assign snd_src[k*ASZ +: ASZ] = pay_q[k][RSZ+DSZ+ASZ +: ASZ];
    assign occ[k*PW +: PW]       = w_occ[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_nd_1ton_router.sv
`default_nettype none

// ============================================================================
// Module   : tb_nd_1ton_router
// Purpose  : Self-checking bench for nd_1ton_router, 3 outputs with ranges
//            0..7 / 8..15 / rest, broadcast at 8'hFF, 4-deep FIFOs.
// Revision : 1.0 - initial release
// ============================================================================

module tb_nd_1ton_router;

  localparam int NO   = 3;
  localparam int ASZ  = 8;
  localparam int DSZ  = 16;
  localparam int RSZ  = 4;
  localparam int FSZ  = 4;
  localparam int PW   = $clog2(FSZ) + 1;
  localparam int MW   = 2*ASZ + DSZ + RSZ;
  localparam int NMSG = 3000;

  logic              i_clk = 1'b0;
  logic              reset = 1'b1;
  logic              ready;
  logic [ASZ-1:0]    rcv_src = '0;
  logic [ASZ-1:0]    rcv_dst = '0;
  logic [DSZ-1:0]    rcv_dat = '0;
  logic [RSZ-1:0]    rcv_red = '0;
  logic              rcv_req = 1'b0;
  logic              rcv_ack;
  logic [NO*ASZ-1:0] snd_src;
  logic [NO*ASZ-1:0] snd_dst;
  logic [NO*DSZ-1:0] snd_dat;
  logic [NO*RSZ-1:0] snd_red;
  logic [NO-1:0]     snd_req;
  logic [NO-1:0]     snd_ack = '0;
  logic [NO*PW-1:0]  occ;

  // Reference model: one expected-order queue per output.
  logic [MW-1:0] exp_q [NO][$];
  int checks   = 0;
  int failures = 0;
  bit tx_done  = 1'b0;

  nd_1ton_router #(
    .NUM_OUT  (NO),
    .ASZ      (ASZ),
    .DSZ      (DSZ),
    .RSZ      (RSZ),
    .FSZ      (FSZ),
    .UPPER    ({8'd15, 8'd7}),
    .BCAST_EN (1'b1),
    .BCAST_ADR(8'hFF)
  ) dut (
    .i_clk  (i_clk),
    .reset  (reset),
    .ready  (ready),
    .rcv_src(rcv_src),
    .rcv_dst(rcv_dst),
    .rcv_dat(rcv_dat),
    .rcv_red(rcv_red),
    .rcv_req(rcv_req),
    .rcv_ack(rcv_ack),
    .snd_src(snd_src),
    .snd_dst(snd_dst),
    .snd_dat(snd_dat),
    .snd_red(snd_red),
    .snd_req(snd_req),
    .snd_ack(snd_ack),
    .occ    (occ)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Which outputs a destination goes to, straight from the address map.
  function automatic logic [NO-1:0] route(input logic [ASZ-1:0] d);
    if (d == 8'hFF) return 3'b111;
    if (d <= 8'd7)  return 3'b001;
    if (d <= 8'd15) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [MW-1:0] mk(input logic [ASZ-1:0] d, input int seq);
    return {8'($urandom), d, 16'(seq), 4'($urandom)};
  endfunction

  function automatic logic [MW-1:0] out_msg(input int k);
    return {snd_src[k*ASZ +: ASZ], snd_dst[k*ASZ +: ASZ],
            snd_dat[k*DSZ +: DSZ], snd_red[k*RSZ +: RSZ]};
  endfunction

  function automatic logic [PW-1:0] occ_of(input int k);
    return occ[k*PW +: PW];
  endfunction

  function automatic void model_push(input logic [MW-1:0] m);
    logic [NO-1:0] t;
    t = route(m[RSZ+DSZ +: ASZ]);
    for (int k = 0; k < NO; k++) if (t[k]) exp_q[k].push_back(m);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NO; k++) exp_q[k].delete();
  endfunction

  // Input handshake: raise req, wait for ack. On ack, drop req and record the
  // message in the model. On timeout req is left high.
  task automatic send(input logic [MW-1:0] m, input int max_cyc, output bit acked);
    int n;
    acked = 1'b0;
    n = 0;
    while (rcv_ack && n < max_cyc) begin
      @(posedge i_clk); #1;
      n++;
    end
    {rcv_src, rcv_dst, rcv_dat, rcv_red} = m;
    rcv_req = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge i_clk); #1;
      if (rcv_ack) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      rcv_req = 1'b0;
      model_push(m);
    end
  endtask

  // Output handshake on channel k. st: 0 done, 1 no request, 2 req stuck high.
  task automatic take(input int k, input int dly, input int max_cyc,
                      output logic [MW-1:0] m, output int st);
    m  = '0;
    st = 1;
    for (int i = 0; i < max_cyc && !snd_req[k]; i++) begin
      @(posedge i_clk); #1;
    end
    if (!snd_req[k]) return;
    repeat (dly) begin
      @(posedge i_clk); #1;
    end
    m = out_msg(k);
    snd_ack[k] = 1'b1;
    for (int i = 0; i < max_cyc && snd_req[k]; i++) begin
      @(posedge i_clk); #1;
    end
    st = snd_req[k] ? 2 : 0;
    snd_ack[k] = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (rcv_ack !== 1'b0) begin failures++; $display("FAIL reset_rcv_ack: got %b want 0", rcv_ack); end
    checks++; if (snd_req !== 3'b000) begin failures++; $display("FAIL reset_snd_req: got %b want 000", snd_req); end
    checks++; if (occ !== '0) begin failures++; $display("FAIL reset_occ: got %h want 0", occ); end
    checks++; if ({snd_src, snd_dst, snd_dat, snd_red} !== '0) begin
      failures++; $display("FAIL reset_payload: got %h want 0", {snd_src, snd_dst, snd_dat, snd_red});
    end
    reset = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise: got %b want 1", ready); end
  endtask

  task automatic test_routing();
    logic [ASZ-1:0] d;
    logic [MW-1:0]  m, r;
    bit             acked;
    int             st;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'd3 : (i == 1) ? 8'd9 : 8'd20;
      m = mk(d, 100 + i);
      send(m, 20, acked);
      checks++; if (!acked) begin failures++; $display("FAIL route_ack[%0d]: got 0 want 1", i); end
      checks++; if (snd_req !== 3'b000) begin failures++; $display("FAIL route_no_bypass[%0d]: got %b want 000", i, snd_req); end
      @(posedge i_clk); #1;
      checks++; if (snd_req !== 3'(1 << i)) begin failures++; $display("FAIL route_req[%0d]: got %b want %b", i, snd_req, 3'(1 << i)); end
      checks++; if (out_msg(i) !== m) begin failures++; $display("FAIL route_payload[%0d]: got %h want %h", i, out_msg(i), m); end
      take(i, 0, 20, r, st);
      checks++; if (st != 0 || r !== m) begin failures++; $display("FAIL route_handshake[%0d]: got %h st=%0d want %h", i, r, st, m); end
    end
    model_clear();
  endtask

  task automatic test_fifo_full();
    logic [MW-1:0] m, r, e, last;
    bit            acked;
    int            st;
    // One message parks in the output register, then FSZ fill the FIFO.
    for (int i = 0; i < FSZ + 1; i++) begin
      m = mk(8'($urandom_range(0, 7)), 200 + i);
      send(m, 20, acked);
      checks++; if (!acked) begin failures++; $display("FAIL full_fill_ack[%0d]: got 0 want 1", i); end
    end
    checks++; if (occ_of(0) !== PW'(FSZ)) begin failures++; $display("FAIL full_occ: got %0d want %0d", occ_of(0), FSZ); end
    last = mk(8'd0, 299);
    send(last, 8, acked);
    checks++; if (acked || rcv_ack !== 1'b0) begin failures++; $display("FAIL full_withheld: got ack=%b want 0", rcv_ack); end
    take(0, 0, 20, r, st);
    e = exp_q[0].size() > 0 ? exp_q[0].pop_front() : '1;
    checks++; if (st != 0 || r !== e) begin failures++; $display("FAIL full_first: got %h st=%0d want %h", r, st, e); end
    acked = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (rcv_ack) begin acked = 1'b1; break; end
      @(posedge i_clk); #1;
    end
    checks++; if (!acked) begin failures++; $display("FAIL full_late_ack: got 0 want 1"); end
    rcv_req = 1'b0;
    if (acked) model_push(last);
    for (int i = 0; i < FSZ + 1; i++) begin
      take(0, 0, 20, r, st);
      e = exp_q[0].size() > 0 ? exp_q[0].pop_front() : '1;
      checks++; if (st != 0 || r !== e) begin failures++; $display("FAIL full_drain[%0d]: got %h st=%0d want %h", i, r, st, e); end
    end
    model_clear();
  endtask

  task automatic test_broadcast();
    logic [MW-1:0] m, r, e, b;
    bit            acked;
    int            st;
    for (int i = 0; i < FSZ + 1; i++) begin
      m = mk(8'($urandom_range(8, 15)), 300 + i);
      send(m, 20, acked);
      checks++; if (!acked) begin failures++; $display("FAIL bcast_fill_ack[%0d]: got 0 want 1", i); end
    end
    b = mk(8'hFF, 399);
    send(b, 8, acked);
    checks++; if (acked) begin failures++; $display("FAIL bcast_withheld: got ack=1 want 0"); end
    checks++; if (occ_of(0) !== '0 || occ_of(2) !== '0) begin
      failures++; $display("FAIL bcast_partial: got occ0=%0d occ2=%0d want 0 0", occ_of(0), occ_of(2));
    end
    checks++; if (occ_of(1) !== PW'(FSZ)) begin failures++; $display("FAIL bcast_occ1: got %0d want %0d", occ_of(1), FSZ); end
    take(1, 0, 20, r, st);
    e = exp_q[1].size() > 0 ? exp_q[1].pop_front() : '1;
    checks++; if (st != 0 || r !== e) begin failures++; $display("FAIL bcast_first: got %h st=%0d want %h", r, st, e); end
    acked = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (rcv_ack) begin acked = 1'b1; break; end
      @(posedge i_clk); #1;
    end
    checks++; if (!acked) begin failures++; $display("FAIL bcast_late_ack: got 0 want 1"); end
    rcv_req = 1'b0;
    if (acked) model_push(b);
    for (int k = 0; k < NO; k++) begin
      for (int i = 0; i < ((k == 1) ? FSZ + 1 : 1); i++) begin
        take(k, 0, 20, r, st);
        e = exp_q[k].size() > 0 ? exp_q[k].pop_front() : '1;
        checks++; if (st != 0 || r !== e) begin failures++; $display("FAIL bcast_drain%0d[%0d]: got %h st=%0d want %h", k, i, r, st, e); end
      end
    end
    model_clear();
  endtask

  task automatic test_push_pop_full();
    logic [MW-1:0] m, r, e;
    bit            acked;
    int            st;
    for (int i = 0; i < FSZ + 1; i++) begin
      m = mk(8'($urandom_range(16, 254)), 400 + i);
      send(m, 20, acked);
      checks++; if (!acked) begin failures++; $display("FAIL pp_fill_ack[%0d]: got 0 want 1", i); end
    end
    for (int i = 0; i < 3*FSZ; i++) begin
      m = mk(8'($urandom_range(16, 254)), 500 + i);
      fork
        send(m, 20, acked);
        take(2, 0, 20, r, st);
      join
      e = exp_q[2].size() > 0 ? exp_q[2].pop_front() : '1;
      checks++; if (st != 0 || r !== e) begin failures++; $display("FAIL pp_order[%0d]: got %h st=%0d want %h", i, r, st, e); end
      checks++; if (!acked || occ_of(2) !== PW'(FSZ)) begin
        failures++; $display("FAIL pp_occ[%0d]: got ack=%b occ=%0d want 1 %0d", i, acked, occ_of(2), FSZ);
      end
    end
    for (int i = 0; i < FSZ + 1; i++) begin
      take(2, 0, 20, r, st);
      e = exp_q[2].size() > 0 ? exp_q[2].pop_front() : '1;
      checks++; if (st != 0 || r !== e) begin failures++; $display("FAIL pp_drain[%0d]: got %h st=%0d want %h", i, r, st, e); end
    end
    model_clear();
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] m;
    bit            acked;
    send(mk(8'd9, 600), 20, acked);
    @(posedge i_clk); #1;
    m = mk(8'd10, 601);
    {rcv_src, rcv_dst, rcv_dat, rcv_red} = m;
    rcv_req = 1'b1;
    for (int n = 0; n < 10 && !rcv_ack; n++) begin
      @(posedge i_clk); #1;
    end
    checks++; if (rcv_ack !== 1'b1 || snd_req[1] !== 1'b1) begin
      failures++; $display("FAIL rstmid_setup: got ack=%b req1=%b want 1 1", rcv_ack, snd_req[1]);
    end
    reset   = 1'b1;
    rcv_req = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (rcv_ack !== 1'b0 || snd_req !== 3'b000 || ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_low: got ack=%b req=%b ready=%b want 0 000 0", rcv_ack, snd_req, ready);
    end
    checks++; if (occ !== '0) begin failures++; $display("FAIL rstmid_occ: got %h want 0", occ); end
    checks++; if ({snd_src, snd_dst, snd_dat, snd_red} !== '0) begin failures++; $display("FAIL rstmid_payload: got nonzero want 0"); end
    reset = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (snd_req !== 3'b000 || occ !== '0) begin
      failures++; $display("FAIL rstmid_flushed: got req=%b occ=%h want 000 0", snd_req, occ);
    end
    model_clear();
  endtask

  task automatic rx_proc(input int k);
    logic [MW-1:0] r, e;
    int            st;
    while (!(tx_done && exp_q[k].size() == 0)) begin
      take(k, $urandom_range(0, 3), 300, r, st);
      if (st == 1) begin
        if (exp_q[k].size() != 0) begin
          checks++; failures++;
          $display("FAIL rand_lost[%0d]: got none want %h", k, exp_q[k][0]);
          break;
        end
      end else if (st == 2) begin
        checks++; failures++;
        $display("FAIL rand_stuck[%0d]: got req=1 want 0", k);
        break;
      end else begin
        checks++;
        if (exp_q[k].size() == 0) begin
          failures++; $display("FAIL rand_dup[%0d]: got %h want none", k, r);
        end else begin
          e = exp_q[k].pop_front();
          if (r !== e) begin failures++; $display("FAIL rand_order[%0d]: got %h want %h", k, r, e); end
        end
      end
    end
  endtask

  task automatic test_random();
    tx_done = 1'b0;
    fork
      begin
        logic [MW-1:0]  m;
        logic [ASZ-1:0] d;
        bit             acked;
        int             sel;
        for (int i = 0; i < NMSG; i++) begin
          sel = $urandom_range(0, 19);
          if (sel == 0)      d = 8'hFF;
          else if (sel < 7)  d = 8'($urandom_range(0, 7));
          else if (sel < 13) d = 8'($urandom_range(8, 15));
          else               d = 8'($urandom_range(16, 254));
          m = mk(d, i);
          send(m, 400, acked);
          checks++;
          if (!acked) begin
            failures++; $display("FAIL rand_send[%0d]: got no ack want ack", i);
            rcv_req = 1'b0;
            break;
          end
          repeat ($urandom_range(0, 2)) begin
            @(posedge i_clk); #1;
          end
        end
        tx_done = 1'b1;
      end
      rx_proc(0);
      rx_proc(1);
      rx_proc(2);
    join
    for (int k = 0; k < NO; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin failures++; $display("FAIL rand_leftover[%0d]: got %0d want 0", k, exp_q[k].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_fifo_full();
    test_broadcast();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
